// File: rtl/ps2_byte_receiver_pkg.sv
// ============================================================================
// Module  : ps2_byte_receiver_pkg
// Brief   : Shared PS/2 receiver definitions: FSM states, frame bit levels,
//           keyboard scan codes and the odd-parity helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_byte_receiver_pkg;

  // Receiver frame-walking states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Line levels of the framing bits
  localparam logic c_START_BIT = 1'b0;
  localparam logic c_STOP_BIT  = 1'b1;

  // Scan codes shared with the keyboard scorer
  localparam logic [7:0] c_SC_BREAK = 8'hF0;
  localparam logic [7:0] c_SC_SPACE = 8'h29;
  localparam logic [7:0] c_SC_A     = 8'h1C;
  localparam logic [7:0] c_SC_S     = 8'h1B;
  localparam logic [7:0] c_SC_D     = 8'h23;
  localparam logic [7:0] c_SC_F     = 8'h2B;
  localparam logic [7:0] c_SC_EMPTY = 8'h05;

  // True when data plus parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_byte_receiver_line_filter.sv
// ============================================================================
// Module  : ps2_byte_receiver_line_filter
// Brief   : 2-flop synchroniser, FILTER_LEN-sample stability filter and a
//           one-cycle strobe on each accepted 1->0 transition.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_byte_receiver_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic i_line,
  output logic o_fall
);

  localparam int c_CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(FILTER_LEN - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_filt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_fall;

  // Synchronise, then accept a new level only after FILTER_LEN equal samples
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_filt  <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_line;
      r_sync2 <= r_sync1;
      r_fall  <= 1'b0;
      if (r_sync2 != r_filt) begin
        if (r_cnt == c_CNT_MAX) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
          // A change away from a high filtered level is a fall
          r_fall <= r_filt;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/ps2_byte_receiver.sv
// ============================================================================
// Module  : ps2_byte_receiver
// Brief   : PS/2 keyboard line deserialiser. Emits each good scan-code byte
//           with a one-cycle strobe; flags parity, framing and timeout errors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_byte_receiver
  import ps2_byte_receiver_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100_000,
  parameter int TO_W        = 17
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [TO_W-1:0] c_TO_LIMIT = TO_W'(TIMEOUT_CYC - 1);

  logic            w_fall;
  logic            r_dat_s1;
  logic            r_dat_s2;
  ps2_state_t      r_state;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_par_ok;
  logic [TO_W-1:0] r_to_cnt;

  ps2_byte_receiver_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_line   (PS2_CLK),
    .o_fall   (w_fall)
  );

  // Data only needs synchronising; it is sampled mid-bit on a clock fall
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_dat_s1 <= PS2_DAT;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Frame FSM with bit shifter, inter-bit timeout and registered output pulses
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_shift          <= '0;
      r_bit_cnt        <= '0;
      r_par_ok         <= 1'b0;
      r_to_cnt         <= '0;
      received_data    <= '0;
      received_data_en <= 1'b0;
      parity_err       <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      received_data_en <= 1'b0;
      parity_err       <= 1'b0;
      frame_err        <= 1'b0;

      if (r_state == ST_IDLE || w_fall) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      // A fall arriving on the limit cycle still counts as in time
      if (r_state != ST_IDLE && !w_fall && r_to_cnt == c_TO_LIMIT) begin
        frame_err <= 1'b1;
        r_state   <= ST_IDLE;
      end else if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (r_dat_s2 == c_START_BIT) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_par_ok <= odd_parity_ok(r_shift, r_dat_s2);
            r_state  <= ST_STOP;
          end
          ST_STOP: begin
            if (r_dat_s2 != c_STOP_BIT) begin
              frame_err <= 1'b1;
            end else if (r_par_ok) begin
              received_data    <= r_shift;
              received_data_en <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ps2_byte_receiver.sv
// ============================================================================
// Module  : tb_ps2_byte_receiver
// Brief   : Self-checking bench for ps2_byte_receiver with a frame-level
//           reference model and randomised scan-code traffic.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_byte_receiver;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 20;
  localparam int K_EN  = 0;
  localparam int K_PAR = 1;
  localparam int K_FRM = 2;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  ps2_byte_receiver #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO),
    .TO_W        (17)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset            (reset),
    .PS2_CLK          (PS2_CLK),
    .PS2_DAT          (PS2_DAT),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .parity_err       (parity_err),
    .frame_err        (frame_err),
    .busy             (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         at;
  } ev_t;

  ev_t        obs[$];
  ev_t        exp_q[$];
  int         cyc = 0;
  int         busy_cnt = 0;
  int         multi_hot = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         last_fall = 0;
  logic [7:0] model_data = 8'h00;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Record every output pulse with the data visible in the same cycle
  always @(negedge CLOCK_50) begin
    if (reset) begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if ((int'(received_data_en) + int'(parity_err) + int'(frame_err)) > 1)
        multi_hot <= multi_hot + 1;
      if (received_data_en)  obs.push_back('{K_EN,  received_data, cyc});
      else if (parity_err)   obs.push_back('{K_PAR, received_data, cyc});
      else if (frame_err)    obs.push_back('{K_FRM, received_data, cyc});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // One PS/2 bit cell: data changes mid-high, then a low half-period
  task automatic ps2_bit(input logic b);
    wait_cyc(HALF / 2);
    PS2_DAT = b;
    wait_cyc(HALF / 2);
    PS2_CLK   = 1'b0;
    last_fall = cyc;
    wait_cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stp);
    PS2_DAT = 1'b1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Reference outcome of one complete frame
  function automatic void model_frame(input logic [7:0] d, input logic par, input logic stp);
    ev_t e;
    e.at = 0;
    if (!stp) begin
      e.kind = K_FRM;
    end else if ((($countones(d) + int'(par)) % 2) == 1) begin
      e.kind     = K_EN;
      model_data = d;
    end else begin
      e.kind = K_PAR;
    end
    e.data = model_data;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset;
    wait_cyc(3);
    n_checks++;
    if ({received_data, received_data_en, parity_err, frame_err, busy} !== 12'h000)
      $display("FAIL reset_outputs: got %h, want 000",
               {received_data, received_data_en, parity_err, frame_err, busy});
    else n_pass++;
    reset = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_single;
    int base;
    base = obs.size();
    exp_q.delete();
    model_frame(8'h1C, good_par(8'h1C), 1'b1);
    send_frame(8'h1C, good_par(8'h1C), 1'b1);
    wait_cyc(4);
    n_checks++;
    if (obs.size() - base !== 1) $display("FAIL single_count: got %0d, want 1", obs.size() - base);
    else n_pass++;
    if (obs.size() > base) begin
      n_checks++;
      if (obs[base].kind !== K_EN || obs[base].data !== 8'h1C)
        $display("FAIL single_data: got kind %0d data %h, want kind 0 data 1c", obs[base].kind, obs[base].data);
      else n_pass++;
      n_checks++;
      if (obs[base].at - last_fall < FL + 2 || obs[base].at - last_fall > FL + 4)
        $display("FAIL single_latency: got %0d, want %0d..%0d", obs[base].at - last_fall, FL + 2, FL + 4);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_busy_after: got %b, want 0", busy);
    else n_pass++;
  endtask

  task automatic run_and_compare(input string name);
    int base;
    base = obs.size();
    foreach (exp_q[i]) ;
  endtask

  task automatic test_back_to_back;
    int base;
    base = obs.size();
    exp_q.delete();
    model_frame(8'hF0, 1'b1, 1'b1);
    model_frame(8'h1B, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1B, 1'b1, 1'b1);
    wait_cyc(4);
    n_checks++;
    if (obs.size() - base !== exp_q.size())
      $display("FAIL b2b_count: got %0d, want %0d", obs.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
      n_checks++;
      if (obs[base+i].kind !== exp_q[i].kind || obs[base+i].data !== exp_q[i].data)
        $display("FAIL b2b_ev%0d: got kind %0d data %h, want kind %0d data %h",
                 i, obs[base+i].kind, obs[base+i].data, exp_q[i].kind, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_errors;
    int base;
    base = obs.size();
    exp_q.delete();
    model_frame(8'h29, 1'b1, 1'b1);
    model_frame(8'h23, good_par(8'h23), 1'b0);
    model_frame(8'h23, ~good_par(8'h23), 1'b0);
    model_frame(8'h2B, good_par(8'h2B), 1'b1);
    send_frame(8'h29, 1'b1, 1'b1);
    send_frame(8'h23, good_par(8'h23), 1'b0);
    send_frame(8'h23, ~good_par(8'h23), 1'b0);
    send_frame(8'h2B, good_par(8'h2B), 1'b1);
    wait_cyc(4);
    n_checks++;
    if (obs.size() - base !== exp_q.size())
      $display("FAIL err_count: got %0d, want %0d", obs.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
      n_checks++;
      if (obs[base+i].kind !== exp_q[i].kind || obs[base+i].data !== exp_q[i].data)
        $display("FAIL err_ev%0d: got kind %0d data %h, want kind %0d data %h",
                 i, obs[base+i].kind, obs[base+i].data, exp_q[i].kind, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    int base;
    int t0;
    base = obs.size();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    t0 = last_fall;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL timeout_busy_mid: got %b, want 1", busy);
    else n_pass++;
    for (int i = 0; i < TO + FL + 40 && obs.size() == base; i++) wait_cyc(1);
    n_checks++;
    if (obs.size() - base !== 1) $display("FAIL timeout_count: got %0d, want 1", obs.size() - base);
    else n_pass++;
    if (obs.size() > base) begin
      n_checks++;
      if (obs[base].kind !== K_FRM || obs[base].data !== model_data)
        $display("FAIL timeout_ev: got kind %0d data %h, want kind 2 data %h",
                 obs[base].kind, obs[base].data, model_data);
      else n_pass++;
      n_checks++;
      if (obs[base].at - t0 < TO + FL || obs[base].at - t0 > TO + FL + 6)
        $display("FAIL timeout_delay: got %0d, want %0d..%0d", obs[base].at - t0, TO + FL, TO + FL + 6);
      else n_pass++;
    end
    wait_cyc(2);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL timeout_busy_after: got %b, want 0", busy);
    else n_pass++;
    base = obs.size();
    send_frame(8'h1C, good_par(8'h1C), 1'b1);
    model_data = 8'h1C;
    wait_cyc(4);
    n_checks++;
    if (obs.size() - base !== 1 || obs[obs.size()-1].kind !== K_EN || obs[obs.size()-1].data !== 8'h1C)
      $display("FAIL timeout_recover: got %0d events, want one en with 1c", obs.size() - base);
    else n_pass++;
  endtask

  task automatic test_glitch_and_reset;
    int base;
    int b0;
    base = obs.size();
    b0   = busy_cnt;
    PS2_CLK = 1'b0;
    wait_cyc(5);
    PS2_CLK = 1'b1;
    wait_cyc(30);
    ps2_bit(1'b1);
    wait_cyc(5);
    n_checks++;
    if (busy_cnt !== b0 || obs.size() !== base)
      $display("FAIL glitch: got busy cycles %0d events %0d, want 0 and 0", busy_cnt - b0, obs.size() - base);
    else n_pass++;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit($urandom_range(0, 1) == 1);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({received_data, received_data_en, parity_err, frame_err, busy} !== 12'h000)
      $display("FAIL reset_midframe: got %h, want 000",
               {received_data, received_data_en, parity_err, frame_err, busy});
    else n_pass++;
    model_data = 8'h00;
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(5);
    send_frame(8'h2B, good_par(8'h2B), 1'b1);
    model_data = 8'h2B;
    wait_cyc(4);
    n_checks++;
    if (obs.size() - base !== 1 || obs[obs.size()-1].kind !== K_EN || obs[obs.size()-1].data !== 8'h2B)
      $display("FAIL reset_recover: got %0d events, want one en with 2b", obs.size() - base);
    else n_pass++;
  endtask

  task automatic test_random;
    int base;
    logic [7:0] d;
    logic par;
    logic stp;
    base = obs.size();
    exp_q.delete();
    for (int n = 0; n < 12; n++) begin
      d   = 8'($urandom);
      par = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
      stp = ($urandom_range(0, 3) != 0);
      model_frame(d, par, stp);
      send_frame(d, par, stp);
    end
    wait_cyc(4);
    n_checks++;
    if (obs.size() - base !== exp_q.size())
      $display("FAIL rand_count: got %0d, want %0d", obs.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++) begin
      n_checks++;
      if (obs[base+i].kind !== exp_q[i].kind || obs[base+i].data !== exp_q[i].data)
        $display("FAIL rand_ev%0d: got kind %0d data %h, want kind %0d data %h",
                 i, obs[base+i].kind, obs[base+i].data, exp_q[i].kind, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_exclusive;
    n_checks++;
    if (multi_hot !== 0) $display("FAIL exclusive_pulses: got %0d overlapping cycles, want 0", multi_hot);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_glitch_and_reset();
    test_random();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop in case a stimulus task ever stalls
  initial begin
    #5ms;
    $display("FAIL watchdog: got time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
